// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcodes, EX/MEM payload.
package execute_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_CMP   = 4'h5,
    OP_SLL   = 4'h6,
    OP_SRL   = 4'h7,
    OP_SRA   = 4'h8,
    OP_SLT   = 4'h9,
    OP_SLTU  = 4'hA,
    OP_MUL   = 4'hB,
    OP_PASSB = 4'hC
  } alu_op_e;

  // Everything the memory stage receives from execute.
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [DATA_W-1:0] pc_plus2;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  rd;
  } exmem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 16-bit ALU with zero flag; unused opcodes yield 0.
module alu
  import execute_stage_pkg::*;
(
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation select; shifts use only the low 4 bits of B.
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_ADD:   result = SrcA + SrcB;
      OP_SUB:   result = SrcA - SrcB;
      OP_AND:   result = SrcA & SrcB;
      OP_OR:    result = SrcA | SrcB;
      OP_XOR:   result = SrcA ^ SrcB;
      OP_CMP:   result = SrcA - SrcB;
      OP_SLL:   result = SrcA << SrcB[3:0];
      OP_SRL:   result = SrcA >> SrcB[3:0];
      OP_SRA:   result = $unsigned($signed(SrcA) >>> SrcB[3:0]);
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU:  result = {{(DATA_W-1){1'b0}}, SrcA < SrcB};
      OP_MUL:   result = SrcA * SrcB;
      OP_PASSB: result = SrcB;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand mux, ALU, branch/jump resolution and EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               regWriteE,
  input  logic               memWriteE,
  input  logic               jumpE,
  input  logic               branchE,
  input  logic               aluSrcE,
  input  logic [1:0]         resultSrcE,
  input  logic [3:0]         aluControlE,
  input  logic [DATA_W-1:0]  RD1E,
  input  logic [DATA_W-1:0]  RD2E,
  input  logic [DATA_W-1:0]  PCPlus2E,
  input  logic [DATA_W-1:0]  PCE,
  input  logic [DATA_W-1:0]  extendedE,
  input  logic [REG_W-1:0]   RdE,
  output logic               PCSrcE,
  output logic [DATA_W-1:0]  PCTargetE,
  output logic               regWriteM,
  output logic               memWriteM,
  output logic [1:0]         resultSrcM,
  output logic [DATA_W-1:0]  PCPlus2M,
  output logic [DATA_W-1:0]  aluResM,
  output logic [DATA_W-1:0]  writeDataM,
  output logic [REG_W-1:0]   RdM
);

  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  exmem_t            exmem_d, exmem_q;

  assign src_b = aluSrcE ? extendedE : RD2E;

  alu u_alu (
    .SrcA   (RD1E),
    .SrcB   (src_b),
    .op     (aluControlE),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Redirect is purely combinational so fetch sees it in the same cycle.
  assign PCSrcE    = jumpE | (branchE & alu_zero);
  assign PCTargetE = PCE + extendedE;

  // Next EX/MEM contents; store data is always RD2E, never the immediate.
  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = regWriteE;
    exmem_d.mem_write  = memWriteE;
    exmem_d.result_src = resultSrcE;
    exmem_d.pc_plus2   = PCPlus2E;
    exmem_d.alu_res    = alu_res;
    exmem_d.write_data = RD2E;
    exmem_d.rd         = RdE;
  end

  // EX/MEM register; reset clears in-flight contents immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exmem_q <= '0;
    else      exmem_q <= exmem_d;
  end

  assign regWriteM  = exmem_q.reg_write;
  assign memWriteM  = exmem_q.mem_write;
  assign resultSrcM = exmem_q.result_src;
  assign PCPlus2M   = exmem_q.pc_plus2;
  assign aluResM    = exmem_q.alu_res;
  assign writeDataM = exmem_q.write_data;
  assign RdM        = exmem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a scoreboard of expected EX/MEM values.
module tb_execute_stage;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [15:0] pc_plus2;
    logic [15:0] alu_res;
    logic [15:0] write_data;
    logic [3:0]  rd;
  } exp_t;

  logic        clk = 1'b0, clk_en = 1'b0;
  logic        rst = 1'b1;
  logic        regWriteE, memWriteE, jumpE, branchE, aluSrcE;
  logic [1:0]  resultSrcE;
  logic [3:0]  aluControlE, RdE;
  logic [15:0] RD1E, RD2E, PCPlus2E, PCE, extendedE;
  logic        PCSrcE;
  logic [15:0] PCTargetE;
  logic        regWriteM, memWriteM;
  logic [1:0]  resultSrcM;
  logic [15:0] PCPlus2M, aluResM, writeDataM;
  logic [3:0]  RdM;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  execute_stage dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .jumpE(jumpE), .branchE(branchE),
    .aluSrcE(aluSrcE), .resultSrcE(resultSrcE), .aluControlE(aluControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCPlus2E(PCPlus2E), .PCE(PCE), .extendedE(extendedE),
    .RdE(RdE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
    .PCPlus2M(PCPlus2M), .aluResM(aluResM), .writeDataM(writeDataM), .RdM(RdM)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".regWriteM"},  32'(regWriteM),  32'd0);
    chk({tag, ".memWriteM"},  32'(memWriteM),  32'd0);
    chk({tag, ".resultSrcM"}, 32'(resultSrcM), 32'd0);
    chk({tag, ".PCPlus2M"},   32'(PCPlus2M),   32'd0);
    chk({tag, ".aluResM"},    32'(aluResM),    32'd0);
    chk({tag, ".writeDataM"}, 32'(writeDataM), 32'd0);
    chk({tag, ".RdM"},        32'(RdM),        32'd0);
  endtask

  // Drive one instruction, check redirect outputs, queue the expected EX/MEM image.
  task automatic drive(input logic rw, mw, jmp, br, asrc, input logic [1:0] rs,
                       input logic [3:0] op, input logic [15:0] a, b, pcp2, pc, ext,
                       input logic [3:0] rd, input logic [15:0] exp_alu,
                       input logic exp_pcsrc, input logic [15:0] exp_tgt, input string tag);
    exp_t e;
    regWriteE = rw; memWriteE = mw; jumpE = jmp; branchE = br; aluSrcE = asrc;
    resultSrcE = rs; aluControlE = op; RD1E = a; RD2E = b; PCPlus2E = pcp2;
    PCE = pc; extendedE = ext; RdE = rd;
    #1;
    chk({tag, ".PCSrcE"},    32'(PCSrcE),    32'(exp_pcsrc));
    chk({tag, ".PCTargetE"}, 32'(PCTargetE), 32'(exp_tgt));
    e = '{reg_write: rw, mem_write: mw, result_src: rs, pc_plus2: pcp2,
          alu_res: exp_alu, write_data: b, rd: rd};
    sb.push_back(e);
  endtask

  // Advance one edge and compare the M outputs against the oldest expectation.
  task automatic step_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".regWriteM"},  32'(regWriteM),  32'(e.reg_write));
    chk({tag, ".memWriteM"},  32'(memWriteM),  32'(e.mem_write));
    chk({tag, ".resultSrcM"}, 32'(resultSrcM), 32'(e.result_src));
    chk({tag, ".PCPlus2M"},   32'(PCPlus2M),   32'(e.pc_plus2));
    chk({tag, ".aluResM"},    32'(aluResM),    32'(e.alu_res));
    chk({tag, ".writeDataM"}, 32'(writeDataM), 32'(e.write_data));
    chk({tag, ".RdM"},        32'(RdM),        32'(e.rd));
  endtask

  typedef struct { logic [3:0] op; logic [15:0] a, b, res; } alu_vec_t;
  alu_vec_t vecs[$];

  initial begin
    // Arbitrary inputs while reset is asserted with the clock stopped.
    regWriteE = 1; memWriteE = 1; jumpE = 0; branchE = 0; aluSrcE = 0;
    resultSrcE = 2'b11; aluControlE = 4'h0; RD1E = 16'h1111; RD2E = 16'h2222;
    PCPlus2E = 16'h3333; PCE = 16'h0100; extendedE = 16'h0020; RdE = 4'h7;
    #2 rst = 1'b0;
    #3;
    chk_all_zero("reset_no_clk");
    chk("reset.PCTargetE", 32'(PCTargetE), 32'h0120);
    #5 rst = 1'b1;
    #2;
    chk_all_zero("post_release_before_edge");

    clk_en = 1'b1;
    @(negedge clk);

    drive(0, 0, 1, 1, 1, 2'b00, 4'h5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0,
          16'h0000, 1'b1, 16'h0000, "jump_cmp_zero");
    step_check("jump_cmp_zero");
    @(negedge clk);

    drive(0, 0, 0, 1, 1, 2'b01, 4'h5, 16'h0005, 16'h1234, 16'h0102, 16'h0100, 16'h0005, 4'h3,
          16'h0000, 1'b1, 16'h0105, "branch_taken");
    step_check("branch_taken");
    @(negedge clk);

    drive(0, 0, 0, 1, 1, 2'b01, 4'h5, 16'h0005, 16'h1234, 16'h0102, 16'h0100, 16'h0004, 4'h3,
          16'h0001, 1'b0, 16'h0104, "branch_not_taken");
    step_check("branch_not_taken");
    @(negedge clk);

    drive(0, 0, 0, 0, 0, 2'b00, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0009, 4'h1,
          16'h0000, 1'b0, 16'h0009, "add_wrap");
    step_check("add_wrap");
    @(negedge clk);

    drive(1, 1, 0, 0, 0, 2'b10, 4'h0, 16'h0003, 16'h0004, 16'h0042, 16'h0000, 16'h0000, 4'hA,
          16'h0007, 1'b0, 16'h0000, "ctrl_pipe");
    step_check("ctrl_pipe");
    @(negedge clk);

    drive(0, 1, 0, 0, 1, 2'b00, 4'h8, 16'h8000, 16'h5555, 16'h0012, 16'h0010, 16'h0004, 4'h2,
          16'hF800, 1'b0, 16'h0014, "sra_imm");
    step_check("sra_imm");

    // Opcode sweep with register operand B; branch set so zero is visible on PCSrcE.
    vecs.push_back('{4'h1, 16'h0003, 16'h0005, 16'hFFFE});
    vecs.push_back('{4'h2, 16'hF0F0, 16'h3C3C, 16'h3030});
    vecs.push_back('{4'h3, 16'hF0F0, 16'h0F01, 16'hFFF1});
    vecs.push_back('{4'h4, 16'hAAAA, 16'hAAAA, 16'h0000});
    vecs.push_back('{4'h6, 16'h0001, 16'h001F, 16'h8000});
    vecs.push_back('{4'h7, 16'h8000, 16'h0004, 16'h0800});
    vecs.push_back('{4'h8, 16'h4000, 16'h0002, 16'h1000});
    vecs.push_back('{4'h9, 16'hFFFF, 16'h0001, 16'h0001});
    vecs.push_back('{4'h9, 16'h0001, 16'hFFFF, 16'h0000});
    vecs.push_back('{4'hA, 16'hFFFF, 16'h0001, 16'h0000});
    vecs.push_back('{4'hA, 16'h0001, 16'hFFFF, 16'h0001});
    vecs.push_back('{4'hB, 16'h0123, 16'h0010, 16'h1230});
    vecs.push_back('{4'hB, 16'h0100, 16'h0100, 16'h0000});
    vecs.push_back('{4'hC, 16'hDEAD, 16'hBEEF, 16'hBEEF});
    vecs.push_back('{4'hD, 16'h1234, 16'h4321, 16'h0000});
    vecs.push_back('{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000});
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1, 0, 0, 1, 0, 2'b01, vecs[i].op, vecs[i].a, vecs[i].b, 16'h0200 + 16'(i),
            16'h0300, 16'h0010, 4'(i), vecs[i].res, vecs[i].res == 16'h0000, 16'h0310,
            $sformatf("op%0h_v%0d", vecs[i].op, i));
      step_check($sformatf("op%0h_v%0d", vecs[i].op, i));
    end

    // Reset mid-operation discards EX/MEM contents without a clock edge.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 2'b11, 4'h0, 16'h0010, 16'h0020, 16'h0044, 16'h0002, 16'h0003, 4'hF,
          16'h0030, 1'b0, 16'h0005, "pre_midreset");
    step_check("pre_midreset");
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    jumpE = 1'b1;
    #1;
    chk("midreset.PCSrcE",    32'(PCSrcE),    32'd1);
    chk("midreset.PCTargetE", 32'(PCTargetE), 32'h0005);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low. Ports are clk and rst.
REQ-002 SHALL: port clk, input, 1 bit; rising-edge clock.
REQ-003 SHALL: port rst, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL: port regWriteE, input, 1 bit; register-write control from decode.
REQ-005 SHALL: port memWriteE, input, 1 bit; memory-write control.
REQ-006 SHALL: port jumpE, input, 1 bit; unconditional jump.
REQ-007 SHALL: port branchE, input, 1 bit; conditional branch (taken on ALU zero).
REQ-008 SHALL: port aluSrcE, input, 1 bit; selects ALU operand B (1 = extendedE, 0 = RD2E).
REQ-009 SHALL: port resultSrcE, input, 2 bits; writeback-source select, pipelined through unchanged.
REQ-010 SHALL: port aluControlE, input, 4 bits; ALU operation code.
REQ-011 SHALL: ports RD1E, RD2E, PCPlus2E, PCE, extendedE, inputs, 16 bits each; operand A, operand B / store data, PC+2, current PC, sign-extended immediate.
REQ-012 SHALL: port RdE, input, 4 bits; destination register.
REQ-013 SHALL: port PCSrcE, output, 1 bit, combinational; redirect-PC request.
REQ-014 SHALL: port PCTargetE, output, 16 bits, combinational; branch/jump target.
REQ-015 SHALL: ports regWriteM, memWriteM (1 bit); resultSrcM (2 bits); PCPlus2M, aluResM, writeDataM (16 bits); RdM (4 bits); all outputs, registered EX/MEM copies.

Function
REQ-016 SHALL: SrcB = aluSrcE ? extendedE : RD2E; SrcA = RD1E.
REQ-017 SHALL: ALU ops are 16-bit, with results truncated mod 2^16:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR
- 0101 CMP (A-B, used for branches)
- 0110 SLL by B[3:0]; 0111 SRL by B[3:0]; 1000 SRA by B[3:0]
- 1001 SLT signed (result 1/0); 1010 SLTU (result 1/0)
- 1011 MUL (low 16 bits); 1100 PASSB
- 1101-1111 produce 0
REQ-018 SHALL: zero flag = (ALU result == 16'h0000), combinational.
REQ-019 SHALL: PCSrcE = jumpE OR (branchE AND zero); jumpE dominates regardless of ALU result.
REQ-020 SHALL: PCTargetE = PCE + extendedE, mod 2^16.
REQ-021 SHALL: on each rising clk edge with rst high, register:
- regWriteE→regWriteM, memWriteE→memWriteM, resultSrcE→resultSrcM
- PCPlus2E→PCPlus2M, ALU result→aluResM, RD2E→writeDataM, RdE→RdM
REQ-022 SHALL: latency through the stage is exactly one cycle; no stall or flush inputs; the stage accepts a new instruction every cycle.
REQ-023 SHALL: writeDataM is always RD2E, never the immediate, independent of aluSrcE.
REQ-024 SHALL: PCSrcE and PCTargetE depend only on current inputs, not on reset state.

Reset
REQ-025 SHALL: while rst is low, all registered outputs are 0 immediately (asynchronously), regardless of clk.
REQ-026 SHALL: after rst is released (goes high), registered outputs keep their reset values until the first rising clk edge, then follow REQ-021.
REQ-027 SHALL: assertion of rst mid-operation discards the in-flight EX/MEM contents.

Structure
REQ-028 SHALL: a shared package holds the 4-bit ALU opcode enum (REQ-017), data width 16 and register-index width 4.
REQ-029 SHALL: the ALU is a separate combinational sub-module named alu (inputs SrcA, SrcB, op; outputs result, zero); the pipeline register logic stays in execute_stage.

Verification
REQ-030 SHALL: bench covers rst low with arbitrary inputs -> all registered outputs 0, even without clk edges.
REQ-031 SHALL: bench covers jumpE=1, branchE=1, aluSrcE=1, op=0101, all data 0 -> PCSrcE=1, PCTargetE=0; after one edge aluResM=0.
REQ-032 SHALL: bench covers branchE=1, jumpE=0, op=0101, RD1E=5, aluSrcE=1, extendedE=5 -> PCSrcE=1; with extendedE=4 -> PCSrcE=0.
REQ-033 SHALL: bench covers op=0000, RD1E=16'hFFFF, RD2E=1, aluSrcE=0 -> after one edge aluResM=0, writeDataM=1 (wrap-around).
REQ-034 SHALL: bench covers regWriteE=1, memWriteE=1, resultSrcE=2'b10, PCPlus2E=16'h0042, RdE=4'hA -> after one edge the M outputs equal those values.
REQ-035 SHALL: bench covers op=1000, RD1E=16'h8000, extendedE=4, aluSrcE=1 -> aluResM=16'hF800; PCE=16'h0010 -> PCTargetE=16'h0014.
